// File: rtl/tile_collision_probe_pkg.sv
// tile_collision_probe_pkg: shared tile-map constants, corner indices and FSM state encoding
package tile_collision_probe_pkg;
    localparam int TILE_SIZE  = 32;
    localparam int FIELD_LEFT = 144;
    localparam int FIELD_TOP  = 35;
    localparam logic [1:0] CORNER_TL = 2'd0;
    localparam logic [1:0] CORNER_TR = 2'd1;
    localparam logic [1:0] CORNER_BL = 2'd2;
    localparam logic [1:0] CORNER_BR = 2'd3;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PROBE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
endpackage

// File: rtl/tile_collision_probe_corner_addr.sv
// tile_collision_probe_corner_addr: combinational corner coordinate with carry detect
//   x, y      : latched sprite top-left
//   idx       : corner index (TL, TR, BL, BR)
//   probe_x/y : truncated corner coordinate
//   overflow  : corner sum carried out of COORD_W bits
module tile_collision_probe_corner_addr
    import tile_collision_probe_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [1:0]         idx,
    output logic [COORD_W-1:0] probe_x,
    output logic [COORD_W-1:0] probe_y,
    output logic               overflow
);
    localparam logic [COORD_W:0] DX = (COORD_W+1)'(SPRITE_W - 1);
    localparam logic [COORD_W:0] DY = (COORD_W+1)'(SPRITE_H - 1);
    logic             w_right;
    logic             w_bottom;
    logic [COORD_W:0] w_sx;
    logic [COORD_W:0] w_sy;
    always_comb begin
        w_right  = idx == CORNER_TR || idx == CORNER_BR;
        w_bottom = idx == CORNER_BL || idx == CORNER_BR;
        w_sx     = {1'b0, x} + (w_right ? DX : '0);
        w_sy     = {1'b0, y} + (w_bottom ? DY : '0);
        probe_x  = w_sx[COORD_W-1:0];
        probe_y  = w_sy[COORD_W-1:0];
        overflow = w_sx[COORD_W] | w_sy[COORD_W];
    end
endmodule

// File: rtl/tile_collision_probe.sv
// tile_collision_probe: walks the four sprite corners through the tile collision port
//   req_valid/req_ready/req_x/req_y : candidate position handshake
//   probe_x/probe_y/probe_hit       : combinational tile-map collision lookup
//   rsp_valid/rsp_ready/rsp_hit/rsp_any : solid-corner mask result
module tile_collision_probe
    import tile_collision_probe_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    output logic [COORD_W-1:0] probe_x,
    output logic [COORD_W-1:0] probe_y,
    input  logic               probe_hit,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [3:0]         rsp_hit,
    output logic               rsp_any
);
    logic [1:0]         r_state;
    logic [1:0]         r_idx;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [3:0]         r_hit;
    logic [COORD_W-1:0] w_cx;
    logic [COORD_W-1:0] w_cy;
    logic               w_ovf;

    tile_collision_probe_corner_addr #(
        .COORD_W (COORD_W),
        .SPRITE_W(SPRITE_W),
        .SPRITE_H(SPRITE_H)
    ) u_corner (
        .x       (r_x),
        .y       (r_y),
        .idx     (r_idx),
        .probe_x (w_cx),
        .probe_y (w_cy),
        .overflow(w_ovf)
    );

    always_comb begin
        req_ready = r_state == ST_IDLE;
        rsp_valid = r_state == ST_RESP;
        probe_x   = r_state == ST_PROBE ? w_cx : '0;
        probe_y   = r_state == ST_PROBE ? w_cy : '0;
        rsp_hit   = r_hit;
        rsp_any   = |r_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_hit   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (req_valid) begin
                r_x     <= req_x;
                r_y     <= req_y;
                r_hit   <= '0;
                r_idx   <= '0;
                r_state <= ST_PROBE;
            end
        end else if (r_state == ST_PROBE) begin
            // a corner that wrapped past the coordinate range is treated as solid
            r_hit[r_idx] <= probe_hit | w_ovf;
            r_idx        <= r_idx + 2'd1;
            if (r_idx == CORNER_BR) r_state <= ST_RESP;
        end else if (rsp_ready) begin
            r_state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_tile_collision_probe.sv
// tb_tile_collision_probe: randomized and directed checks against a tile-map reference model
module tb_tile_collision_probe;
    import tile_collision_probe_pkg::*;
    localparam int CW   = 10;
    localparam int SW   = 32;
    localparam int SH   = 32;
    localparam int LIM  = 1 << CW;
    localparam int COLS = 20;
    localparam int ROWS = 15;

    logic          clk = 0;
    logic          rst = 1;
    logic          req_valid = 0;
    logic          req_ready;
    logic [CW-1:0] req_x = '0;
    logic [CW-1:0] req_y = '0;
    logic [CW-1:0] probe_x;
    logic [CW-1:0] probe_y;
    logic          probe_hit;
    logic          rsp_valid;
    logic          rsp_ready = 0;
    logic [3:0]    rsp_hit;
    logic          rsp_any;

    bit map [ROWS][COLS];
    bit off_solid = 1;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tile_collision_probe #(.COORD_W(CW), .SPRITE_W(SW), .SPRITE_H(SH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .probe_x(probe_x), .probe_y(probe_y), .probe_hit(probe_hit),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_any(rsp_any)
    );

    function automatic bit solid(int x, int y);
        if (x < FIELD_LEFT || x >= FIELD_LEFT + COLS*TILE_SIZE ||
            y < FIELD_TOP  || y >= FIELD_TOP + ROWS*TILE_SIZE) return off_solid;
        return map[(y - FIELD_TOP) / TILE_SIZE][(x - FIELD_LEFT) / TILE_SIZE];
    endfunction

    assign probe_hit = solid(int'(probe_x), int'(probe_y));

    function automatic int cx_of(int x, int c);
        return x + ((c % 2) == 1 ? SW - 1 : 0);
    endfunction

    function automatic int cy_of(int y, int c);
        return y + (c >= 2 ? SH - 1 : 0);
    endfunction

    function automatic logic [3:0] model(int x, int y);
        logic [3:0] m;
        m = '0;
        for (int c = 0; c < 4; c++) begin
            int sx = cx_of(x, c);
            int sy = cy_of(y, c);
            m[c] = (sx >= LIM || sy >= LIM) ? 1'b1 : solid(sx, sy);
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_map();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) map[r][c] = 0;
    endtask

    // entered and left at a negedge with the DUT idle
    task automatic run_txn(input int x, input int y, input int stall);
        logic [3:0] exp;
        exp = model(x, y);
        req_x = CW'(x);
        req_y = CW'(y);
        req_valid = 1;
        rsp_ready = 0;
        chk("ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 0;
        req_x = CW'($urandom);
        req_y = CW'($urandom);
        for (int c = 0; c < 4; c++) begin
            chk("ready_probe", req_ready, 0);
            chk("probe_x", probe_x, cx_of(x, c) % LIM);
            chk("probe_y", probe_y, cy_of(y, c) % LIM);
            chk("valid_probe", rsp_valid, 0);
            @(negedge clk);
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_hit", rsp_hit, exp);
        chk("rsp_any", rsp_any, |exp);
        chk("probe_x_resp", probe_x, 0);
        chk("probe_y_resp", probe_y, 0);
        for (int s = 0; s < stall; s++) begin
            req_valid = 1;
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_hit", rsp_hit, exp);
            chk("stall_ready", req_ready, 0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        req_valid = 0;
        chk("valid_drop", rsp_valid, 0);
        chk("hit_hold", rsp_hit, exp);
        chk("ready_back", req_ready, 1);
    endtask

    initial begin
        clear_map();
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_hit", rsp_hit, 0);
        chk("rst_any", rsp_any, 0);
        chk("rst_px", probe_x, 0);
        chk("rst_py", probe_y, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        run_txn(144, 35, 0);
        chk("empty_mask", rsp_hit, 4'b0000);
        run_txn(200, 100, 0);
        map[0][1] = 1;
        run_txn(160, 35, 0);
        chk("tile_mask", rsp_hit, 4'b1010);
        clear_map();
        off_solid = 0;
        run_txn(1000, 35, 0);
        chk("ovf_mask", rsp_hit, 4'b1010);
        off_solid = 1;

        run_txn(300, 200, 3);
        run_txn(400, 300, 0);

        map[0][1] = 1;
        req_x = 160;
        req_y = 35;
        req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_px", probe_x, 0);
        chk("arst_py", probe_y, 0);
        chk("arst_ready", req_ready, 1);
        chk("arst_valid", rsp_valid, 0);
        chk("arst_hit", rsp_hit, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_valid", rsp_valid, 0);
        end
        run_txn(160, 35, 0);

        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) map[r][c] = ($urandom_range(0, 3) == 0);
            off_solid = $urandom_range(0, 1);
            run_txn($urandom_range(100, LIM - 1), $urandom_range(0, LIM - 1), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
